sdram_readback_tx: RTL and testbench

// - Reverse path of the USB->SDRAM framebuffer writer: reads SDRAM in bursts and streams the words back to the host as bytes.
// - Sits in the mem_clk domain between the SDRAM controller app read port (shared with the video reader) and the FTDI TX byte FIFO.
// - The host uses it for framebuffer readback and for memory test.

---
 rtl/sdram_readback_tx_pkg.sv | 21 ++
 rtl/sdram_readback_tx_buf.sv | 64 ++++++
 rtl/sdram_readback_tx.sv | 120 ++++++++++++
 tb/tb_sdram_readback_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_readback_tx_pkg.sv
// Shared constants, state encoding and byte-order helper for the SDRAM readback path.
package sdram_readback_tx_pkg;

    localparam int DEF_ADDR_W    = 25;
    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_LEN_W     = 16;
    localparam bit LSB_FIRST     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    // Selects which half of a 16-bit word goes out for a given byte index parity.
    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic odd);
        pick_byte = (odd ^ !LSB_FIRST) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sdram_readback_tx_buf.sv
// One-burst word buffer: fills from the SDRAM read-data beats, then serialises
// the words to the TX FIFO as bytes through a valid/ready output stage.
module sdram_readback_tx_buf
    import sdram_readback_tx_pkg::*;
#(
    parameter int DEPTH = DEF_BURST_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        wr_last,
    input  logic        rd_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rd_last
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BPTR_W = PTR_W + 1;

    logic [15:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [BPTR_W-1:0] rptr;
    logic [BPTR_W-1:0] next_ptr;

    assign next_ptr = rptr + BPTR_W'(1);
    assign wr_last  = wr_en && (wptr == PTR_W'(DEPTH - 1));
    assign rd_last  = tx_valid && tx_ready && (rptr == BPTR_W'(2 * DEPTH - 1));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    // rptr always names the byte currently presented on tx_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wr_last ? '0 : wptr + PTR_W'(1);
            end
            if (tx_valid && tx_ready) begin
                if (rd_last) begin
                    tx_valid <= 1'b0;
                    rptr     <= '0;
                end else begin
                    rptr    <= next_ptr;
                    tx_data <= pick_byte(mem[next_ptr[BPTR_W-1:1]], next_ptr[0]);
                end
            end else if (rd_en && !tx_valid) begin
                tx_valid <= 1'b1;
                tx_data  <= pick_byte(mem[rptr[BPTR_W-1:1]], rptr[0]);
            end
        end
    end

endmodule

// File: rtl/sdram_readback_tx.sv
// SDRAM-to-host readback: issues burst reads on the shared app port and streams
// each returned burst to the FTDI TX FIFO as bytes before requesting the next.
//
//   state      | meaning
//   IDLE       | waiting for a command; cmd_ready high
//   REQ        | read request pending, masked while the video reader owns the port
//   WAIT_DATA  | collecting BURST_LEN read beats into the buffer
//   DRAIN      | sending 2*BURST_LEN bytes to the TX FIFO
module sdram_readback_tx
    import sdram_readback_tx_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_bursts,
    input  logic              mem_busy,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_req_ack,
    input  logic              mem_rd_valid,
    input  logic [15:0]       mem_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic              req_r;
    logic              done_r;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              wr_en;
    logic              wr_last;
    logic              rd_en;
    logic              rd_last;

    assign wr_en       = (state == ST_WAIT_DATA) && mem_rd_valid;
    assign rd_en       = (state == ST_DRAIN);
    assign mem_rd_req  = req_r & ~mem_busy;
    assign mem_rd_addr = addr;
    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign done        = done_r;

    sdram_readback_tx_buf #(
        .DEPTH (BURST_LEN)
    ) u_buf (
        .clk      (mem_clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (mem_rd_data),
        .wr_last  (wr_last),
        .rd_en    (rd_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rd_last  (rd_last)
    );

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_r     <= 1'b0;
            done_r    <= 1'b0;
            addr      <= '0;
            remaining <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_bursts;
                        if (cmd_bursts == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                            req_r <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack while the request is masked belongs to the other reader.
                    if (mem_rd_req && mem_req_ack) begin
                        req_r <= 1'b0;
                        state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (wr_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd_last) begin
                        addr      <= addr + ADDR_W'(BURST_LEN);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            done_r <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_REQ;
                            req_r <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_readback_tx.sv
// Self-checking bench: SDRAM controller responder, TX sink and a queue-based
// model of the expected request addresses and byte stream.
module tb_sdram_readback_tx;

    localparam int AW = 25;
    localparam int BL = 8;
    localparam int LW = 16;

    logic          mem_clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_bursts;
    logic          mem_busy;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_req_ack;
    logic          mem_rd_valid;
    logic [15:0]   mem_rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]   salt;
    logic          force_ack;
    int            tx_mode;
    int            resp_phase;
    int            beats_sent;
    logic [7:0]    got [0:127];
    int            got_n;
    logic [AW-1:0] last_req_addr;

    always #5 mem_clk = ~mem_clk;

    sdram_readback_tx dut (
        .mem_clk      (mem_clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_bursts   (cmd_bursts),
        .mem_busy     (mem_busy),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_req_ack  (mem_req_ack),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a, input logic [15:0] s);
        return a[15:0] ^ 16'h1000 ^ s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // SDRAM controller: acks 2 cycles after a visible request, then returns BL beats.
    initial begin
        int req_cycles;
        int lat;
        logic [AW-1:0] data_addr;
        req_cycles = 0;
        lat = 0;
        data_addr = '0;
        resp_phase = 0;
        beats_sent = 0;
        mem_req_ack = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge mem_clk);
            #1;
            mem_req_ack = force_ack;
            mem_rd_valid = 1'b0;
            case (resp_phase)
                0: begin
                    if (mem_rd_req) begin
                        req_cycles++;
                        if (req_cycles == 3) begin
                            mem_req_ack = 1'b1;
                            data_addr = mem_rd_addr;
                            req_cycles = 0;
                            lat = $urandom_range(1, 4);
                            beats_sent = 0;
                            resp_phase = 1;
                        end
                    end else begin
                        req_cycles = 0;
                    end
                end
                1: begin
                    lat--;
                    if (lat == 0) resp_phase = 2;
                end
                default: begin
                    if ($urandom_range(0, 3) != 0) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_data = mem_word(data_addr + AW'(beats_sent), salt);
                        beats_sent++;
                        if (beats_sent == BL) resp_phase = 0;
                    end
                end
            endcase
        end
    end

    // TX FIFO side.
    initial begin
        int k;
        k = 0;
        tx_ready = 1'b1;
        forever begin
            @(negedge mem_clk);
            case (tx_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = (k % 4 == 0) || (k % 4 == 3);
                default: tx_ready = ($urandom_range(0, 2) != 0);
            endcase
            k++;
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        logic [7:0]    exp_bytes [$];
        logic [AW-1:0] exp_addr [$];
        logic          done_due;
        logic          prev_hold;
        logic [7:0]    prev_data;
        logic [AW-1:0] a;
        logic [15:0]   w;
        done_due = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        got_n = 0;
        last_req_addr = '0;
        forever begin
            @(negedge mem_clk);
            #2;
            if (rst) begin
                exp_bytes.delete();
                exp_addr.delete();
                done_due = 1'b0;
                prev_hold = 1'b0;
            end else begin
                chk("done", 32'(done), 32'(done_due));
                done_due = 1'b0;
                chk("busy", 32'(busy), 32'(exp_bytes.size() != 0));
                chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
                chk("req_vs_mem_busy", 32'(mem_rd_req & mem_busy), 32'(0));
                if (prev_hold) begin
                    chk("tx_valid_hold", 32'(tx_valid), 32'(1));
                    chk("tx_data_hold", 32'(tx_data), 32'(prev_data));
                end
                if (tx_valid) begin
                    if (exp_bytes.size() == 0) begin
                        chk("spurious_tx", 32'(tx_valid), 32'(0));
                    end else if (tx_ready) begin
                        chk("tx_byte", 32'(tx_data), 32'(exp_bytes[0]));
                        if (got_n < 128) got[got_n] = tx_data;
                        got_n++;
                        void'(exp_bytes.pop_front());
                        if (exp_bytes.size() == 0) done_due = 1'b1;
                    end
                end
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
                if (mem_rd_req && mem_req_ack) begin
                    if (exp_addr.size() == 0) begin
                        chk("spurious_req", 32'(mem_rd_req), 32'(0));
                    end else begin
                        chk("req_addr", 32'(mem_rd_addr), 32'(exp_addr[0]));
                        chk("req_no_overlap", 32'(exp_bytes.size()), 32'(2 * BL * exp_addr.size()));
                        last_req_addr = mem_rd_addr;
                        void'(exp_addr.pop_front());
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    got_n = 0;
                    for (int b = 0; b < int'(cmd_bursts); b++) begin
                        a = cmd_addr + AW'(b * BL);
                        exp_addr.push_back(a);
                        for (int i = 0; i < BL; i++) begin
                            w = mem_word(a + AW'(i), salt);
                            exp_bytes.push_back(w[7:0]);
                            exp_bytes.push_back(w[15:8]);
                        end
                    end
                    if (cmd_bursts == '0) done_due = 1'b1;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_mem_rd_req"}, 32'(mem_rd_req), 32'(0));
        chk({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'(0));
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'(0));
        chk({tag, "_tx_data"}, 32'(tx_data), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic issue(input logic [AW-1:0] a, input int n);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_bursts = LW'(n);
        @(negedge mem_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd_busy, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            mem_busy = rnd_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
            #3;
            if (done) begin
                cyc = i;
                break;
            end
            @(negedge mem_clk);
        end
        mem_busy = 1'b0;
        if (cyc < 0) chk({tag, "_done_timeout"}, 32'(0), 32'(1));
        @(negedge mem_clk);
    endtask

    task automatic wait_resp_idle(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            if (resp_phase == 0) break;
            @(negedge mem_clk);
        end
        if (i == 200) chk({tag, "_resp_idle_timeout"}, 32'(0), 32'(1));
    endtask

    initial begin
        int cyc;
        int i;
        logic [AW-1:0] ra;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_bursts = '0;
        mem_busy = 1'b0;
        force_ack = 1'b0;
        salt = '0;
        tx_mode = 0;
        repeat (3) @(negedge mem_clk);
        #3;
        check_reset("por");
        @(negedge mem_clk);
        rst = 1'b0;
        repeat (2) @(negedge mem_clk);

        // Single burst with known words.
        issue(25'h000100, 1);
        wait_done("single", 400, 1'b0, cyc);
        chk("single_bytes", 32'(got_n), 32'(16));
        chk("single_b0", 32'(got[0]), 32'h00);
        chk("single_b1", 32'(got[1]), 32'h11);
        chk("single_b2", 32'(got[2]), 32'h01);
        chk("single_b14", 32'(got[14]), 32'h07);
        chk("single_b15", 32'(got[15]), 32'h11);
        chk("single_req_addr", 32'(last_req_addr), 32'h000100);

        // Request masked by the other reader; a stray ack must not be taken.
        mem_busy = 1'b1;
        salt = 16'h5a5a;
        issue(25'h0123450, 1);
        for (int k = 0; k < 20; k++) begin
            force_ack = (k == 10);
            #3;
            chk("req_masked", 32'(mem_rd_req), 32'(0));
            @(negedge mem_clk);
        end
        force_ack = 1'b0;
        mem_busy = 1'b0;
        #3;
        chk("req_after_busy", 32'(mem_rd_req), 32'(1));
        @(negedge mem_clk);
        wait_done("masked", 400, 1'b0, cyc);
        chk("masked_req_addr", 32'(last_req_addr), 32'h0123450);

        // Back-pressure pattern 1,0,0,1 over 3 bursts.
        tx_mode = 1;
        salt = 16'($urandom);
        issue(AW'($urandom), 3);
        wait_done("pattern", 1000, 1'b0, cyc);
        chk("pattern_bytes", 32'(got_n), 32'(48));

        // Address wrap past the top of memory.
        tx_mode = 2;
        salt = 16'($urandom);
        issue(25'h1FFFFF8, 2);
        wait_done("wrap", 1000, 1'b0, cyc);
        chk("wrap_second_req", 32'(last_req_addr), 32'h0000000);
        chk("wrap_bytes", 32'(got_n), 32'(32));

        // Zero-length command.
        tx_mode = 0;
        issue(25'h0000200, 0);
        wait_done("zero", 10, 1'b0, cyc);
        chk("zero_done_latency", 32'(cyc), 32'(0));
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("zero_no_req", 32'(mem_rd_req), 32'(0));
            @(negedge mem_clk);
        end

        // Reset after 3 beats of a burst.
        salt = 16'($urandom);
        issue(AW'($urandom), 2);
        for (i = 0; i < 200; i++) begin
            if (resp_phase == 2 && beats_sent == 3) break;
            @(negedge mem_clk);
        end
        if (i == 200) chk("abort_beats_timeout", 32'(0), 32'(1));
        rst = 1'b1;
        @(negedge mem_clk);
        #3;
        check_reset("abort");
        @(negedge mem_clk);
        rst = 1'b0;
        wait_resp_idle("abort");
        repeat (5) @(negedge mem_clk);
        salt = 16'($urandom);
        issue(25'h0000800, 1);
        wait_done("after_abort", 400, 1'b0, cyc);
        chk("after_abort_bytes", 32'(got_n), 32'(16));
        chk("after_abort_req", 32'(last_req_addr), 32'h0000800);

        // Randomised commands with random port contention and back-pressure.
        tx_mode = 2;
        for (int n = 0; n < 10; n++) begin
            ra = (n % 3 == 0) ? (25'h1FFFFF0 + AW'($urandom_range(0, 15))) : AW'($urandom);
            salt = 16'($urandom);
            issue(ra, $urandom_range(0, 3));
            wait_done("random", 2000, 1'b1, cyc);
            wait_resp_idle("random");
        end

        repeat (3) @(negedge mem_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
